// File: rtl/dmem_responder_pkg.sv
// Shared types, limits and the lane-alignment rule for the data-memory responder.
package dmem_responder_pkg;

   localparam int unsigned DMEM_MAX_LATENCY = 15;
   localparam int unsigned DMEM_CNT_W       = $clog2(DMEM_MAX_LATENCY + 1);
   localparam int unsigned XLEN             = 32;
   localparam int unsigned BE_W             = XLEN / 8;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_WAIT,
      DM_RESP
   } dmem_state_t;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [BE_W-1:0] be;
   } mem_req_t;

   // Word and halfword lane sets that would straddle a word boundary at this byte offset
   function automatic logic dmem_misaligned(input logic [1:0] lsb, input logic [BE_W-1:0] be);
      logic mis;
      mis = 1'b0;
      case (be)
         4'b1111:          mis = (lsb != 2'b00);
         4'b0011, 4'b1100: mis = lsb[0];
         default:          mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Word-organised RAM with per-byte write enables, synchronous write and asynchronous read.
module dmem_ram
   import dmem_responder_pkg::*;
#(
   parameter  int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_addr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [BE_W-1:0] i_be,
   output logic [XLEN-1:0] o_rdata
);

   logic [XLEN-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (i_be[i]) begin
               r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's load/store port: one request at a time, fixed latency,
// response held until the core takes it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned     DEPTH_WORDS = 1024,
   parameter int unsigned     LATENCY     = 2,
   parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [BE_W-1:0] req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned          AW         = $clog2(DEPTH_WORDS);
   localparam logic [XLEN-1:0]       SPAN_BYTES = XLEN'(DEPTH_WORDS * 4);
   localparam logic [DMEM_CNT_W-1:0] CNT_LOAD   = DMEM_CNT_W'(LATENCY - 1);
   localparam logic [DMEM_CNT_W-1:0] CNT_ONE    = DMEM_CNT_W'(1);

   mem_req_t              w_req;
   dmem_state_t           r_state;
   dmem_state_t           w_state_nxt;
   logic [DMEM_CNT_W-1:0] r_cnt;
   logic [DMEM_CNT_W-1:0] w_cnt_nxt;
   logic                  r_req_ready;
   logic                  w_req_ready_nxt;
   logic                  r_rsp_valid;
   logic                  w_rsp_valid_nxt;
   logic [XLEN-1:0]       r_rsp_rdata;
   logic [XLEN-1:0]       w_rsp_rdata_nxt;
   logic                  r_rsp_err;
   logic                  w_rsp_err_nxt;
   logic [XLEN-1:0]       w_off;
   logic [XLEN-1:0]       w_ram_rdata;
   logic                  w_err;
   logic                  w_accept;
   logic                  w_ram_we;

   assign w_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

   // Offset wraps at 32 bits, so addresses below the base land far out of range
   assign w_off    = w_req.addr - BASE_ADDR;
   assign w_err    = (w_off >= SPAN_BYTES) | dmem_misaligned(w_req.addr[1:0], w_req.be);
   assign w_accept = req_valid & r_req_ready;
   assign w_ram_we = w_accept & w_req.we & ~w_err;

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_off[AW+1:2]),
      .i_wdata (w_req.wdata),
      .i_be    (w_req.be),
      .o_rdata (w_ram_rdata)
   );

   // State and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= DM_IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   // Next state; load data is captured at accept, stores and faults return zero
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      case (r_state)
         DM_IDLE: begin
            if (w_accept) begin
               w_rsp_err_nxt   = w_err;
               w_rsp_rdata_nxt = (w_req.we | w_err) ? '0 : w_ram_rdata;
               if (LATENCY == 1) begin
                  w_state_nxt     = DM_RESP;
                  w_rsp_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = DM_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
         DM_WAIT: begin
            if (r_cnt == CNT_ONE) begin
               w_state_nxt     = DM_RESP;
               w_cnt_nxt       = '0;
               w_rsp_valid_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         DM_RESP: begin
            if (rsp_ready) begin
               w_state_nxt     = DM_IDLE;
               w_rsp_valid_nxt = 1'b0;
               w_rsp_rdata_nxt = '0;
               w_rsp_err_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = DM_IDLE;
            w_cnt_nxt       = '0;
            w_rsp_valid_nxt = 1'b0;
         end
      endcase
      w_req_ready_nxt = (w_state_nxt == DM_IDLE);
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1, different bases) against a
// transaction-level model of memory contents and response timing.
module tb_dmem_responder;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned IW    = $clog2(DEPTH);
   localparam int unsigned SPAN  = DEPTH * 4;
   localparam int unsigned LAT0  = 2;
   localparam int unsigned LAT1  = 1;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n     [2] = '{1'b0, 1'b0};
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Model: memory image plus the one outstanding transaction per instance
   logic [31:0] m_mem   [2][DEPTH];
   bit          m_busy  [2];
   int unsigned m_age   [2];
   bit          m_oor   [2];
   logic [31:0] m_rdata [2];
   bit          m_err   [2];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] base_of(input bit d);
      return d ? BASE1 : BASE0;
   endfunction

   function automatic int unsigned lat_of(input bit d);
      return d ? LAT1 : LAT0;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned L = (g == 0) ? LAT0 : LAT1;
      localparam logic [31:0] B = (g == 0) ? BASE0 : BASE1;

      dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .LATENCY     (L),
         .BASE_ADDR   (B)
      ) u_dut (
         .clk       (clk),
         .reset     (rst_n[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g])
      );

      // Advance the model on each edge, then compare every output one step later
      always @(posedge clk or negedge rst_n[g]) begin : cmp
         logic [31:0]     a;
         logic            inr;
         logic            mis;
         logic            bad;
         logic            exp_v;
         logic [IW-1:0]   idx;
         longint unsigned la;
         if (!rst_n[g]) begin
            m_busy[g] = 1'b0;
            m_oor[g]  = 1'b0;
         end else if (!m_oor[g]) begin
            m_oor[g] = 1'b1;
         end else if (!m_busy[g]) begin
            if (req_valid[g]) begin
               a   = req_addr[g];
               la  = 64'(a);
               inr = (la >= 64'(B)) && (la < 64'(B) + 64'(SPAN));
               case (req_be[g])
                  4'b1111:          mis = (a[1:0] != 2'b00);
                  4'b0011, 4'b1100: mis = a[0];
                  default:          mis = 1'b0;
               endcase
               bad        = !inr || mis;
               idx        = IW'((a - B) >> 2);
               m_rdata[g] = 32'h0;
               if (!bad) begin
                  if (req_we[g]) begin
                     for (int i = 0; i < 4; i++)
                        if (req_be[g][i]) m_mem[g][idx][8*i +: 8] = req_wdata[g][8*i +: 8];
                  end else begin
                     m_rdata[g] = m_mem[g][idx];
                  end
               end
               m_err[g]  = bad;
               m_busy[g] = 1'b1;
               m_age[g]  = 0;
            end
         end else if ((m_age[g] >= L - 1) && rsp_ready[g]) begin
            m_busy[g] = 1'b0;
         end else if (m_age[g] < 64) begin
            m_age[g] = m_age[g] + 1;
         end
         #1;
         exp_v = m_busy[g] && (m_age[g] >= L - 1);
         chk($sformatf("rsp_valid d%0d", g), 32'(rsp_valid[g]), 32'(exp_v));
         chk($sformatf("req_ready d%0d", g), 32'(req_ready[g]), 32'(m_oor[g] && !m_busy[g]));
         if (exp_v) begin
            chk($sformatf("rsp_rdata d%0d", g), rsp_rdata[g], m_rdata[g]);
            chk($sformatf("rsp_err d%0d", g), 32'(rsp_err[g]), 32'(m_err[g]));
         end
         if (!rst_n[g]) begin
            chk($sformatf("rst rdata d%0d", g), rsp_rdata[g], 32'h0);
            chk($sformatf("rst err d%0d", g), 32'(rsp_err[g]), 32'h0);
         end
      end
   end

   // One complete request/response; optional garbage on the request side while busy
   task automatic xact(input bit d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input bit rnd,
                       output logic [31:0] rd, output logic er, output int lat);
      int t;
      rd  = 32'h0;
      er  = 1'b0;
      lat = 0;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      req_be[d]    = be;
      rsp_ready[d] = 1'b0;
      t = 0;
      while (!req_ready[d] && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("accept wait d%0d", d), 32'(req_ready[d]), 32'h1);
      if (!req_ready[d]) begin
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      t = 0;
      while (!rsp_valid[d] && t < 40) begin
         if (rnd) begin
            rsp_ready[d] = 1'($urandom_range(0, 1));
            req_valid[d] = 1'($urandom_range(0, 1));
            req_we[d]    = 1'($urandom_range(0, 1));
            req_addr[d]  = $urandom;
            req_wdata[d] = $urandom;
            req_be[d]    = 4'($urandom);
         end
         @(negedge clk);
         t++;
      end
      rsp_ready[d] = 1'b0;
      req_valid[d] = 1'b0;
      chk($sformatf("response wait d%0d", d), 32'(rsp_valid[d]), 32'h1);
      if (!rsp_valid[d]) return;
      lat = t + 1;
      repeat (hold) @(negedge clk);
      rd = rsp_rdata[d];
      er = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
   endtask

   // Accept a full-word store, then pulse reset before the response is taken
   task automatic store_then_reset(input bit d, input logic [31:0] addr, input logic [31:0] wd);
      int t;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      req_be[d]    = 4'hF;
      rsp_ready[d] = 1'b0;
      t = 0;
      while (!req_ready[d] && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("t6 accept wait d%0d", d), 32'(req_ready[d]), 32'h1);
      @(posedge clk);
      #2;
      req_valid[d] = 1'b0;
      rst_n[d]     = 1'b0;
      #1;
      chk($sformatf("t6 rst rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'h0);
      chk($sformatf("t6 rst req_ready d%0d", d), 32'(req_ready[d]), 32'h0);
      @(negedge clk);
      rst_n[d] = 1'b1;
      @(negedge clk);
      chk($sformatf("t6 req_ready after release d%0d", d), 32'(req_ready[d]), 32'h1);
   endtask

   task automatic run_dut(input bit d);
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] b;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [3:0]  be_tab [8];
      int unsigned sel;
      b      = base_of(d);
      be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};

      for (int w = 0; w < int'(DEPTH); w++) begin
         xact(d, 1'b1, b + 32'(w * 4), $urandom, 4'hF, 0, 1'b0, rd, er, lat);
         chk($sformatf("init err d%0d", d), 32'(er), 32'h0);
      end

      xact(d, 1'b1, b + 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t1 store err d%0d", d), 32'(er), 32'h0);
      chk($sformatf("t1 store rdata d%0d", d), rd, 32'h0);
      chk($sformatf("t1 store latency d%0d", d), 32'(lat), lat_of(d));
      xact(d, 1'b0, b + 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t1 load rdata d%0d", d), rd, 32'hDEADBEEF);
      chk($sformatf("t1 load err d%0d", d), 32'(er), 32'h0);
      chk($sformatf("t1 load latency d%0d", d), 32'(lat), lat_of(d));

      xact(d, 1'b1, b + 32'h20, 32'h11223344, 4'hF, 0, 1'b0, rd, er, lat);
      xact(d, 1'b1, b + 32'h20, 32'h000000AA, 4'h1, 0, 1'b0, rd, er, lat);
      xact(d, 1'b0, b + 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t2 byte merge d%0d", d), rd, 32'h112233AA);
      chk($sformatf("t2 model word d%0d", d), m_mem[d][6'd8], 32'h112233AA);

      xact(d, 1'b1, b, 32'h5A5A5A5A, 4'hF, 0, 1'b0, rd, er, lat);
      xact(d, 1'b0, b + 32'(SPAN), 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t3 oor load err d%0d", d), 32'(er), 32'h1);
      chk($sformatf("t3 oor load rdata d%0d", d), rd, 32'h0);
      xact(d, 1'b1, b + 32'(SPAN), 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t3 oor store err d%0d", d), 32'(er), 32'h1);
      chk($sformatf("t3 oor store latency d%0d", d), 32'(lat), lat_of(d));
      xact(d, 1'b0, b, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t3 word0 unchanged d%0d", d), rd, 32'h5A5A5A5A);

      xact(d, 1'b0, b + 32'h10, 32'h0, 4'hF, 5, 1'b0, rd, er, lat);
      chk($sformatf("t4 held rdata d%0d", d), rd, 32'hDEADBEEF);
      chk($sformatf("t4 req_ready after take d%0d", d), 32'(req_ready[d]), 32'h1);

      xact(d, 1'b0, b + 32'h22, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t5 misaligned word err d%0d", d), 32'(er), 32'h1);
      chk($sformatf("t5 misaligned word rdata d%0d", d), rd, 32'h0);
      xact(d, 1'b0, b + 32'h22, 32'h0, 4'hC, 0, 1'b0, rd, er, lat);
      chk($sformatf("t5 upper half err d%0d", d), 32'(er), 32'h0);
      chk($sformatf("t5 upper half rdata d%0d", d), rd, 32'h112233AA);

      xact(d, 1'b1, b + 32'h10, 32'h01234567, 4'h0, 0, 1'b0, rd, er, lat);
      chk($sformatf("be0 store err d%0d", d), 32'(er), 32'h0);
      xact(d, 1'b0, b + 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("be0 store no-op d%0d", d), rd, 32'hDEADBEEF);

      store_then_reset(d, b + 32'h30, 32'hCAFEF00D);
      xact(d, 1'b0, b + 32'h30, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
      chk($sformatf("t6 store survives reset d%0d", d), rd, 32'hCAFEF00D);
      chk($sformatf("t6 load err d%0d", d), 32'(er), 32'h0);

      for (int k = 0; k < 150; k++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      addr = b + 32'(SPAN) + 32'($urandom_range(0, 255));
         else if (sel == 1) addr = b - 32'($urandom_range(1, 64));
         else               addr = b + 32'($urandom_range(0, SPAN - 1));
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : be_tab[$urandom_range(0, 7)];
         xact(d, 1'($urandom_range(0, 1)), addr, $urandom, be, $urandom_range(0, 3), 1'b1,
              rd, er, lat);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = 32'h0;
         req_wdata[i] = 32'h0;
         req_be[i]    = 4'h0;
         rsp_ready[i] = 1'b0;
      end
      #12;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("reset rsp_valid d%0d", i), 32'(rsp_valid[i]), 32'h0);
         chk($sformatf("reset req_ready d%0d", i), 32'(req_ready[i]), 32'h0);
         chk($sformatf("reset rsp_rdata d%0d", i), rsp_rdata[i], 32'h0);
         chk($sformatf("reset rsp_err d%0d", i), 32'(rsp_err[i]), 32'h0);
      end
      #10;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++)
         chk($sformatf("req_ready after release d%0d", i), 32'(req_ready[i]), 32'h1);
      for (int di = 0; di < 2; di++) run_dut(1'(di));
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
